axi4lite_reg_bridge: RTL and testbench
======================================

# axi4lite_reg_bridge

AXI4-Lite slave that converts bus transactions into single-cycle accesses on the GPIO register-core port (write address/strobe/data, read address, registered read data and error). Sits between the system interconnect and the register core, serialising reads and writes, because the core shares one address decode between read and write. It returns core write errors as SLVERR and handles one transaction at a time.

## Interface
- ADDR_W, 10: AXI byte-address width, 3..10; word index = ADDR[ADDR_W-1:2], zero-extended to 8 bits.
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iAWADDR  in  ADDR_W  write address
- iAWVALID  in  1 / oAWREADY  out  1
- iWDATA  in  32 / iWSTRB  in  4 / iWVALID  in  1 / oWREADY  out  1
- oBRESP  out  2 / oBVALID  out  1 / iBREADY  in  1
- iARADDR  in  ADDR_W / iARVALID  in  1 / oARREADY  out  1
- oRDATA  out  32 / oRRESP  out  2 / oRVALID  out  1 / iRREADY  in  1
- oWADR  out  8  core write word address
- oWR  out  1  core write strobe, one cycle per write
- oWDAT  out  32  core write data
- oRADR  out  8  core read word address
- iRDAT  in  32  core read data, valid one cycle after oRADR presented with oWR=0
- iERR  in  1  core error, valid one cycle after the oWR cycle

## Operation
- States: IDLE, WR_EXEC, WR_ERR, WR_RESP, RD_EXEC, RD_CAP, RD_RESP.
- Init flag: reset 0, set on first clock after reset release; all READY outputs gated by it.
- AW holding register + full flag: oAWREADY = init & ~aw_full, in any state; handshake captures address, sets aw_full. W likewise (data+strobe, w_full, oWREADY). AW and W accepted in either order or same cycle.
- Write pending = aw_full & w_full. Priority flag prio: reset = write; set to read after each write response completes, to write after each read response completes.
- IDLE: oARREADY = init & (~pending | prio==read). AR handshake -> capture address, go RD_EXEC. Else if pending & (~iARVALID | prio==write): WSTRB==4'hF -> WR_EXEC; otherwise clear aw_full/w_full, BRESP=SLVERR, go WR_RESP (oWR never asserted).
- WR_EXEC (1 cycle): oWR=1, oWADR/oWDAT from holding regs; clear aw_full/w_full at exit -> WR_ERR.
- WR_ERR (1 cycle): BRESP = iERR ? SLVERR(2'b10) : OKAY(2'b00) -> WR_RESP.
- WR_RESP: oBVALID=1 until iBREADY; then IDLE.
- RD_EXEC (1 cycle): oRADR = captured word index, oWR=0 -> RD_CAP.
- RD_CAP (1 cycle): oRDATA <= iRDAT, RRESP=OKAY -> RD_RESP.
- RD_RESP: oRVALID=1 until iRREADY; then IDLE.
- oWR=0 outside WR_EXEC; oRADR holds last read index otherwise; oWADR/oWDAT reflect holding regs.
- oBRESP/oRDATA/oRRESP stable while VALID high.

## Timing
- Reset values: all READY/VALID 0, oWR 0, oWADR/oRADR 0, oWDAT/oRDATA 0, BRESP/RRESP 00, state IDLE, prio=write, holding flags empty.
- Reset mid-transaction: immediate return to IDLE, pending/in-flight transactions discarded, no BVALID/RVALID issued.
- Grant cycle C0 (IDLE): write -> oWR at C1, iERR sampled C2, oBVALID from C3. Partial-strobe write -> oBVALID from C1.
- Earliest write grant: cycle after the later of AW/W handshakes.
- Read AR handshake C0 -> oRADR valid C1, data captured C2, oRVALID from C3.
- At most one core access in flight; oWR never coincides with a read address change.
- BREADY/RREADY held low: state holds indefinitely; new AW/W may be captured into empty holding regs meanwhile.

## Test plan
- Write AW=0x004, W=0x0000_00FF, strobe F, core iERR=0 -> oWR single pulse with oWADR=1, oWDAT=0xFF at C1; BVALID C3, BRESP=00.
- Read ARADDR=0x004, core iRDAT=0x0000_00FF one cycle after oRADR=1 -> RVALID at C3, RDATA=0xFF, RRESP=00.
- Write AW=0x010 with iERR=1 in C2 -> BRESP=10; W before AW by 3 cycles -> same result.
- WSTRB=4'h3 -> no oWR pulse, BVALID next cycle, BRESP=10.
- AR and complete write pending together after reset -> write first; with both re-presented after -> read first (alternation).
- Hold BREADY=0 10 cycles, assert iRST mid-response -> BVALID drops, all outputs reset values, next read completes normally.

Source files
------------

// File: rtl/axi4lite_reg_bridge_if.sv
// AXI4-Lite slave channels plus the single-cycle register-core port, bundled as
// one interface. The bridge uses the slave modport; the bus or bench driving it uses master.
interface axi4lite_reg_bridge_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] iAWADDR;
    logic              iAWVALID;
    logic              oAWREADY;
    logic [31:0]       iWDATA;
    logic [3:0]        iWSTRB;
    logic              iWVALID;
    logic              oWREADY;
    logic [1:0]        oBRESP;
    logic              oBVALID;
    logic              iBREADY;
    logic [ADDR_W-1:0] iARADDR;
    logic              iARVALID;
    logic              oARREADY;
    logic [31:0]       oRDATA;
    logic [1:0]        oRRESP;
    logic              oRVALID;
    logic              iRREADY;
    logic [7:0]        oWADR;
    logic              oWR;
    logic [31:0]       oWDAT;
    logic [7:0]        oRADR;
    logic [31:0]       iRDAT;
    logic              iERR;

    modport slave (
        input  iAWADDR, iAWVALID, iWDATA, iWSTRB, iWVALID, iBREADY,
        input  iARADDR, iARVALID, iRREADY, iRDAT, iERR,
        output oAWREADY, oWREADY, oBRESP, oBVALID, oARREADY,
        output oRDATA, oRRESP, oRVALID, oWADR, oWR, oWDAT, oRADR
    );

    modport master (
        output iAWADDR, iAWVALID, iWDATA, iWSTRB, iWVALID, iBREADY,
        output iARADDR, iARVALID, iRREADY, iRDAT, iERR,
        input  oAWREADY, oWREADY, oBRESP, oBVALID, oARREADY,
        input  oRDATA, oRRESP, oRVALID, oWADR, oWR, oWDAT, oRADR
    );
endinterface

// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite to register-core bridge: one transaction at a time, reads and writes
// serialised with alternating priority because the core shares its address decode.
module axi4lite_reg_bridge #(
    parameter int ADDR_W = 10
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    axi4lite_reg_bridge_if.slave bus
);
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WR_EXEC, WR_ERR, WR_RESP, RD_EXEC, RD_CAP, RD_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              init_q, init_d;
    logic              prio_q, prio_d;        // 0: write preferred, 1: read preferred
    logic              aw_full_q, aw_full_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic [7:0]        radr_q, radr_d;
    logic              wr_q, wr_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              pending;
    logic              aw_ready, w_ready, ar_ready;
    logic              aw_hs, w_hs, ar_hs;
    logic [7:0]        wadr_ext, ar_word_ext;
    logic              unused_addr_lsbs;

    // Word indices are zero-extended to the core's 8-bit address space.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_zext
            if (gi < IDX_W) begin : g_bit
                assign wadr_ext[gi]    = aw_idx_q[gi];
                assign ar_word_ext[gi] = bus.iARADDR[gi+2];
            end else begin : g_zero
                assign wadr_ext[gi]    = 1'b0;
                assign ar_word_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign unused_addr_lsbs = ^{bus.iAWADDR[1:0], bus.iARADDR[1:0]};

    assign pending  = aw_full_q & w_full_q;
    assign aw_ready = init_q & ~aw_full_q;
    assign w_ready  = init_q & ~w_full_q;
    assign ar_ready = init_q & (state_q == IDLE) & (~pending | prio_q);
    assign aw_hs    = aw_ready & bus.iAWVALID;
    assign w_hs     = w_ready & bus.iWVALID;
    assign ar_hs    = ar_ready & bus.iARVALID;

    always_comb begin
        state_d   = state_q;
        init_d    = 1'b1;
        prio_d    = prio_q;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        radr_d    = radr_q;
        wr_d      = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        // Holding registers fill in any state, so a new write can queue behind a stalled response.
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = bus.iAWADDR[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = bus.iWDATA;
            w_strb_d = bus.iWSTRB;
        end

        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    radr_d  = ar_word_ext;
                    state_d = RD_EXEC;
                end else if (pending && (!bus.iARVALID || !prio_q)) begin
                    if (w_strb_q == 4'hF) begin
                        wr_d    = 1'b1;
                        state_d = WR_EXEC;
                    end else begin
                        // The core has no byte lanes, so partial writes are refused outright.
                        aw_full_d = 1'b0;
                        w_full_d  = 1'b0;
                        bresp_d   = RESP_SLVERR;
                        bvalid_d  = 1'b1;
                        state_d   = WR_RESP;
                    end
                end
            end
            WR_EXEC: begin
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                state_d   = WR_ERR;
            end
            WR_ERR: begin
                bresp_d  = bus.iERR ? RESP_SLVERR : RESP_OKAY;
                bvalid_d = 1'b1;
                state_d  = WR_RESP;
            end
            WR_RESP: begin
                if (bus.iBREADY) begin
                    bvalid_d = 1'b0;
                    prio_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_EXEC: state_d = RD_CAP;
            RD_CAP: begin
                rdata_d  = bus.iRDAT;
                rresp_d  = RESP_OKAY;
                rvalid_d = 1'b1;
                state_d  = RD_RESP;
            end
            RD_RESP: begin
                if (bus.iRREADY) begin
                    rvalid_d = 1'b0;
                    prio_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= IDLE;
            init_q    <= 1'b0;
            prio_q    <= 1'b0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            radr_q    <= '0;
            wr_q      <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            prio_q    <= prio_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            radr_q    <= radr_d;
            wr_q      <= wr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bus.oAWREADY = aw_ready;
    assign bus.oWREADY  = w_ready;
    assign bus.oARREADY = ar_ready;
    assign bus.oBVALID  = bvalid_q;
    assign bus.oBRESP   = bresp_q;
    assign bus.oRVALID  = rvalid_q;
    assign bus.oRDATA   = rdata_q;
    assign bus.oRRESP   = rresp_q;
    assign bus.oWR      = wr_q;
    assign bus.oWADR    = wadr_ext;
    assign bus.oWDAT    = w_data_q;
    assign bus.oRADR    = radr_q;
endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed bench for axi4lite_reg_bridge: cycle-exact checks of write, read,
// error, partial-strobe, arbitration and reset behaviour.
module tb_axi4lite_reg_bridge;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    axi4lite_reg_bridge_if #(.ADDR_W(10)) bus ();

    axi4lite_reg_bridge #(.ADDR_W(10)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.iAWADDR = '0; bus.iAWVALID = 1'b0;
        bus.iWDATA = '0;  bus.iWSTRB = '0; bus.iWVALID = 1'b0;
        bus.iBREADY = 1'b0;
        bus.iARADDR = '0; bus.iARVALID = 1'b0; bus.iRREADY = 1'b0;
        bus.iRDAT = '0;   bus.iERR = 1'b0;

        // reset state
        tick(); tick();
        check("rst_awready", 32'(bus.oAWREADY), 32'h0);
        check("rst_wready",  32'(bus.oWREADY),  32'h0);
        check("rst_arready", 32'(bus.oARREADY), 32'h0);
        check("rst_bvalid",  32'(bus.oBVALID),  32'h0);
        check("rst_rvalid",  32'(bus.oRVALID),  32'h0);
        check("rst_wr",      32'(bus.oWR),      32'h0);
        check("rst_wadr",    32'(bus.oWADR),    32'h0);
        check("rst_radr",    32'(bus.oRADR),    32'h0);
        check("rst_bresp",   32'(bus.oBRESP),   32'h0);
        check("rst_rresp",   32'(bus.oRRESP),   32'h0);
        rst = 1'b0;
        check("init_gate_awready", 32'(bus.oAWREADY), 32'h0);
        tick();
        check("init_awready", 32'(bus.oAWREADY), 32'h1);

        // T1: full write, addr 0x004, data 0xFF, iERR=0
        bus.iAWADDR = 10'h004; bus.iAWVALID = 1'b1;
        bus.iWDATA = 32'h0000_00FF; bus.iWSTRB = 4'hF; bus.iWVALID = 1'b1;
        tick();
        bus.iAWVALID = 1'b0; bus.iWVALID = 1'b0;
        check("t1_c0_awready", 32'(bus.oAWREADY), 32'h0);
        check("t1_c0_wr", 32'(bus.oWR), 32'h0);
        tick();
        check("t1_c1_wr",   32'(bus.oWR),   32'h1);
        check("t1_c1_wadr", 32'(bus.oWADR), 32'h1);
        check("t1_c1_wdat", bus.oWDAT,      32'h0000_00FF);
        tick();
        check("t1_c2_wr",     32'(bus.oWR),     32'h0);
        check("t1_c2_bvalid", 32'(bus.oBVALID), 32'h0);
        tick();
        check("t1_c3_bvalid", 32'(bus.oBVALID), 32'h1);
        check("t1_c3_bresp",  32'(bus.oBRESP),  32'h0);
        bus.iBREADY = 1'b1;
        tick();
        bus.iBREADY = 1'b0;
        check("t1_bdone", 32'(bus.oBVALID), 32'h0);
        $display("write addr=0x004 data=0x000000ff strb=f done");

        // T2: read addr 0x004, core returns 0xFF in C2
        bus.iARADDR = 10'h004; bus.iARVALID = 1'b1;
        bus.iRDAT = 32'hDEAD_BEEF;
        check("t2_arready", 32'(bus.oARREADY), 32'h1);
        tick();
        bus.iARVALID = 1'b0;
        check("t2_c1_radr", 32'(bus.oRADR), 32'h1);
        check("t2_c1_wr",   32'(bus.oWR),   32'h0);
        tick();
        check("t2_c2_rvalid", 32'(bus.oRVALID), 32'h0);
        bus.iRDAT = 32'h0000_00FF;
        tick();
        bus.iRDAT = 32'hDEAD_BEEF;
        check("t2_c3_rvalid", 32'(bus.oRVALID), 32'h1);
        check("t2_c3_rdata",  bus.oRDATA,       32'h0000_00FF);
        check("t2_c3_rresp",  32'(bus.oRRESP),  32'h0);
        tick();
        check("t2_hold_rvalid", 32'(bus.oRVALID), 32'h1);
        check("t2_hold_rdata",  bus.oRDATA,       32'h0000_00FF);
        bus.iRREADY = 1'b1;
        tick();
        bus.iRREADY = 1'b0;
        check("t2_rdone", 32'(bus.oRVALID), 32'h0);
        $display("read addr=0x004 data=0x%08h done", 32'h0000_00FF);

        // T3: W three cycles before AW, core error -> SLVERR
        bus.iWDATA = 32'h1234_5678; bus.iWSTRB = 4'hF; bus.iWVALID = 1'b1;
        check("t3_wready", 32'(bus.oWREADY), 32'h1);
        tick();
        bus.iWVALID = 1'b0;
        check("t3_wready_full", 32'(bus.oWREADY), 32'h0);
        tick(); tick();
        check("t3_no_early_wr", 32'(bus.oWR), 32'h0);
        bus.iAWADDR = 10'h010; bus.iAWVALID = 1'b1;
        tick();
        bus.iAWVALID = 1'b0;
        check("t3_c0_wr", 32'(bus.oWR), 32'h0);
        tick();
        check("t3_c1_wr",   32'(bus.oWR),   32'h1);
        check("t3_c1_wadr", 32'(bus.oWADR), 32'h4);
        check("t3_c1_wdat", bus.oWDAT,      32'h1234_5678);
        tick();
        bus.iERR = 1'b1;
        tick();
        bus.iERR = 1'b0;
        check("t3_c3_bvalid", 32'(bus.oBVALID), 32'h1);
        check("t3_c3_bresp",  32'(bus.oBRESP),  32'h2);
        bus.iBREADY = 1'b1;
        tick();
        bus.iBREADY = 1'b0;
        check("t3_bdone", 32'(bus.oBVALID), 32'h0);
        $display("write addr=0x010 data=0x12345678 core-error done");

        // T4: partial strobe -> SLVERR next cycle, no core write
        bus.iAWADDR = 10'h008; bus.iAWVALID = 1'b1;
        bus.iWDATA = 32'h0000_AAAA; bus.iWSTRB = 4'h3; bus.iWVALID = 1'b1;
        tick();
        bus.iAWVALID = 1'b0; bus.iWVALID = 1'b0;
        check("t4_c0_bvalid", 32'(bus.oBVALID), 32'h0);
        check("t4_c0_wr",     32'(bus.oWR),     32'h0);
        tick();
        check("t4_c1_bvalid", 32'(bus.oBVALID), 32'h1);
        check("t4_c1_bresp",  32'(bus.oBRESP),  32'h2);
        check("t4_c1_wr",     32'(bus.oWR),     32'h0);
        bus.iBREADY = 1'b1;
        tick();
        bus.iBREADY = 1'b0;
        check("t4_bdone", 32'(bus.oBVALID), 32'h0);
        $display("write addr=0x008 strb=3 rejected done");

        // T5: arbitration after reset: write first, then read, then write
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.iAWADDR = 10'h00C; bus.iAWVALID = 1'b1;
        bus.iWDATA = 32'h0000_0055; bus.iWSTRB = 4'hF; bus.iWVALID = 1'b1;
        tick();
        bus.iAWVALID = 1'b0; bus.iWVALID = 1'b0;
        bus.iARADDR = 10'h020; bus.iARVALID = 1'b1;
        check("t5_arready_blocked", 32'(bus.oARREADY), 32'h0);
        tick();
        check("t5_c1_wr",   32'(bus.oWR),      32'h1);
        check("t5_c1_wadr", 32'(bus.oWADR),    32'h3);
        check("t5_c1_arrdy", 32'(bus.oARREADY), 32'h0);
        tick(); tick();
        check("t5_c3_bvalid", 32'(bus.oBVALID), 32'h1);
        check("t5_c3_bresp",  32'(bus.oBRESP),  32'h0);
        bus.iAWADDR = 10'h014; bus.iAWVALID = 1'b1;
        bus.iWDATA = 32'h0000_0077; bus.iWSTRB = 4'hF; bus.iWVALID = 1'b1;
        check("t5_awready_in_resp", 32'(bus.oAWREADY), 32'h1);
        tick();
        bus.iAWVALID = 1'b0; bus.iWVALID = 1'b0;
        check("t5_bvalid_held",  32'(bus.oBVALID),  32'h1);
        check("t5_awready_full", 32'(bus.oAWREADY), 32'h0);
        bus.iBREADY = 1'b1;
        tick();
        bus.iBREADY = 1'b0;
        check("t5_bdone",        32'(bus.oBVALID),  32'h0);
        check("t5_arready_prio", 32'(bus.oARREADY), 32'h1);
        $display("write addr=0x00c data=0x00000055 done (write won)");
        tick();
        bus.iARVALID = 1'b0;
        check("t5_rd_c1_radr", 32'(bus.oRADR), 32'h8);
        check("t5_rd_c1_wr",   32'(bus.oWR),   32'h0);
        tick();
        bus.iRDAT = 32'hCAFE_0001;
        tick();
        bus.iRDAT = 32'h0;
        check("t5_rd_rvalid", 32'(bus.oRVALID), 32'h1);
        check("t5_rd_rdata",  bus.oRDATA,       32'hCAFE_0001);
        bus.iRREADY = 1'b1;
        tick();
        bus.iRREADY = 1'b0;
        check("t5_rdone", 32'(bus.oRVALID), 32'h0);
        $display("read addr=0x020 data=0xcafe0001 done (read won)");
        tick();
        check("t5_w2_c1_wr",   32'(bus.oWR),   32'h1);
        check("t5_w2_c1_wadr", 32'(bus.oWADR), 32'h5);
        check("t5_w2_c1_wdat", bus.oWDAT,      32'h0000_0077);
        tick(); tick();
        check("t5_w2_bvalid", 32'(bus.oBVALID), 32'h1);
        check("t5_w2_bresp",  32'(bus.oBRESP),  32'h0);
        bus.iBREADY = 1'b1;
        tick();
        bus.iBREADY = 1'b0;
        $display("write addr=0x014 data=0x00000077 done");

        // T6: stalled write response, reset mid-response, then a clean read
        bus.iAWADDR = 10'h018; bus.iAWVALID = 1'b1;
        bus.iWDATA = 32'h0000_0099; bus.iWSTRB = 4'hF; bus.iWVALID = 1'b1;
        tick();
        bus.iAWVALID = 1'b0; bus.iWVALID = 1'b0;
        tick(); tick(); tick();
        check("t6_bvalid", 32'(bus.oBVALID), 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_bvalid_stall", 32'(bus.oBVALID), 32'h1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_bvalid",  32'(bus.oBVALID),  32'h0);
        check("t6_rst_awready", 32'(bus.oAWREADY), 32'h0);
        check("t6_rst_arready", 32'(bus.oARREADY), 32'h0);
        check("t6_rst_wr",      32'(bus.oWR),      32'h0);
        check("t6_rst_wadr",    32'(bus.oWADR),    32'h0);
        check("t6_rst_wdat",    bus.oWDAT,         32'h0);
        check("t6_rst_radr",    32'(bus.oRADR),    32'h0);
        check("t6_rst_rdata",   bus.oRDATA,        32'h0);
        $display("write addr=0x018 aborted by reset");
        tick();
        rst = 1'b0;
        tick();
        check("t6_bvalid_after", 32'(bus.oBVALID), 32'h0);
        bus.iARADDR = 10'h03C; bus.iARVALID = 1'b1;
        check("t6_arready", 32'(bus.oARREADY), 32'h1);
        tick();
        bus.iARVALID = 1'b0;
        check("t6_radr", 32'(bus.oRADR), 32'hF);
        tick();
        bus.iRDAT = 32'h0BAD_F00D;
        tick();
        bus.iRDAT = 32'h0;
        check("t6_rvalid", 32'(bus.oRVALID), 32'h1);
        check("t6_rdata",  bus.oRDATA,       32'h0BAD_F00D);
        check("t6_rresp",  32'(bus.oRRESP),  32'h0);
        bus.iRREADY = 1'b1;
        tick();
        bus.iRREADY = 1'b0;
        check("t6_rdone", 32'(bus.oRVALID), 32'h0);
        $display("read addr=0x03c data=0x0badf00d done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
